// File: rtl/queue_counter_if.sv
// Sensor inputs and occupancy/strobe outputs of the queue counter.
// master = sensor side driving photocells; slave = counter.
interface queue_counter_if;
   logic       back_sensor;
   logic       front_sensor;
   logic [2:0] pcount;
   logic       full;
   logic       empty;
   logic       enter_stb;
   logic       leave_stb;
   logic       rej_stb;

   modport master (
      output back_sensor,
      output front_sensor,
      input  pcount,
      input  full,
      input  empty,
      input  enter_stb,
      input  leave_stb,
      input  rej_stb
   );

   modport slave (
      input  back_sensor,
      input  front_sensor,
      output pcount,
      output full,
      output empty,
      output enter_stb,
      output leave_stb,
      output rej_stb
   );
endinterface

// File: rtl/queue_counter.sv
// Saturating 0-7 queue occupancy counter driven by tail/head photocell rising edges.
// Latency 3 edges sensor-to-pcount, or 3+DEB_CYCLES when QC_DEBOUNCE_EN adds a per-sensor filter.
module queue_counter #(
   parameter int unsigned DEB_CYCLES = 4
) (
   input  logic            clk,
   input  logic            rst,
   queue_counter_if.slave  bus
);

   localparam logic [2:0] PC_MAX = 3'd7;
   localparam int         BACK   = 0;
   localparam int         FRONT  = 1;

   if (DEB_CYCLES == 0 || DEB_CYCLES > 15) begin : g_bad_deb
      $error("queue_counter: DEB_CYCLES must be within 1..15");
   end

`ifdef QC_DEBOUNCE_EN
   localparam int unsigned    CNT_W    = 4;
   localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
`endif

   // Per-sensor front end: synchronizer, optional filter, edge history.
   typedef struct packed {
      logic             s1;
      logic             s2;
`ifdef QC_DEBOUNCE_EN
      logic             flt;
      logic [CNT_W-1:0] cnt;
`endif
      logic             hist;
   } sns_t;

   sns_t       sns_q [2];
   sns_t       sns_d [2];
   logic [1:0] raw;
   logic [1:0] lvl;
   logic [1:0] rise;

   logic [2:0] pcount_q, pcount_d;
   logic       full_q,   full_d;
   logic       empty_q,  empty_d;
   logic       enter_q,  enter_d;
   logic       leave_q,  leave_d;
   logic       rej_q,    rej_d;

   assign raw[BACK]  = bus.back_sensor;
   assign raw[FRONT] = bus.front_sensor;

   always_comb begin
      for (int i = 0; i < 2; i++) begin
         sns_d[i]    = sns_q[i];
         sns_d[i].s1 = raw[i];
         sns_d[i].s2 = sns_q[i].s1;
`ifdef QC_DEBOUNCE_EN
         // Filter only follows after DEB_CYCLES consecutive disagreeing samples.
         if (sns_q[i].s2 == sns_q[i].flt) begin
            sns_d[i].cnt = '0;
         end else if (sns_q[i].cnt == DEB_LAST) begin
            sns_d[i].flt = sns_q[i].s2;
            sns_d[i].cnt = '0;
         end else begin
            sns_d[i].cnt = sns_q[i].cnt + CNT_W'(1);
         end
         lvl[i] = sns_q[i].flt;
`else
         lvl[i] = sns_q[i].s2;
`endif
         sns_d[i].hist = lvl[i];
         rise[i]       = lvl[i] & ~sns_q[i].hist;
      end
   end

   always_comb begin
      pcount_d = pcount_q;
      enter_d  = 1'b0;
      leave_d  = 1'b0;
      rej_d    = 1'b0;
      if (rise[BACK] && rise[FRONT]) begin
         // One in, one out: occupancy unchanged even at the limits.
         enter_d = 1'b1;
         leave_d = 1'b1;
      end else if (rise[BACK]) begin
         if (pcount_q != PC_MAX) begin
            pcount_d = pcount_q + 3'd1;
            enter_d  = 1'b1;
         end else begin
            rej_d = 1'b1;
         end
      end else if (rise[FRONT]) begin
         if (pcount_q != 3'd0) begin
            pcount_d = pcount_q - 3'd1;
            leave_d  = 1'b1;
         end else begin
            rej_d = 1'b1;
         end
      end
      full_d  = (pcount_d == PC_MAX);
      empty_d = (pcount_d == 3'd0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 2; i++) begin
            // Reset as "blocked" so a beam already broken is not counted on release.
            sns_q[i].s1   <= 1'b1;
            sns_q[i].s2   <= 1'b1;
`ifdef QC_DEBOUNCE_EN
            sns_q[i].flt  <= 1'b1;
            sns_q[i].cnt  <= '0;
`endif
            sns_q[i].hist <= 1'b1;
         end
         pcount_q <= 3'd0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
         enter_q  <= 1'b0;
         leave_q  <= 1'b0;
         rej_q    <= 1'b0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            sns_q[i] <= sns_d[i];
         end
         pcount_q <= pcount_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
         enter_q  <= enter_d;
         leave_q  <= leave_d;
         rej_q    <= rej_d;
      end
   end

   assign bus.pcount    = pcount_q;
   assign bus.full      = full_q;
   assign bus.empty     = empty_q;
   assign bus.enter_stb = enter_q;
   assign bus.leave_stb = leave_q;
   assign bus.rej_stb   = rej_q;

   a_full_flag: assert property (@(posedge clk) disable iff (rst)
      full_q == (pcount_q == PC_MAX));
   a_empty_flag: assert property (@(posedge clk) disable iff (rst)
      empty_q == (pcount_q == 3'd0));
   a_rej_excl: assert property (@(posedge clk) disable iff (rst)
      !(rej_q && (enter_q || leave_q)));

endmodule

// File: tb/tb_queue_counter.sv
// Bench for queue_counter: vector table of single events from preloaded counts,
// directed reset/debounce sequences, and random sensor traffic against a delay-queue model.
`timescale 1ns/1ps
module tb_queue_counter;

   localparam int unsigned DEB = 4;
`ifdef QC_DEBOUNCE_EN
   localparam int LAT  = 3 + DEB;
   localparam int HI   = DEB + 2;
   localparam int LO   = DEB + 3;
   localparam int MINL = DEB + 2;
   localparam int GAP  = DEB + 2;
`else
   localparam int LAT  = 3;
   localparam int HI   = 4;
   localparam int LO   = 6;
   localparam int MINL = 1;
   localparam int GAP  = 3;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;

   queue_counter_if bus ();

   queue_counter #(.DEB_CYCLES(DEB)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   // Reference model: a rising edge seen at a sampling edge takes effect LAT-1 edges later.
   int         m_pc = 0;
   logic       m_en = 1'b0, m_lv = 1'b0, m_rj = 1'b0;
   logic       m_pb = 1'b1, m_pf = 1'b1;
   logic [1:0] pend [$];

   always @(posedge clk) begin : model
      logic [1:0] ev;
      if (rst) begin
         m_pc = 0; m_en = 1'b0; m_lv = 1'b0; m_rj = 1'b0;
         m_pb = 1'b1; m_pf = 1'b1;
         pend.delete();
      end else begin
         pend.push_back({bus.back_sensor & ~m_pb, bus.front_sensor & ~m_pf});
         m_pb = bus.back_sensor;
         m_pf = bus.front_sensor;
         m_en = 1'b0; m_lv = 1'b0; m_rj = 1'b0;
         if (pend.size() >= LAT) begin
            ev = pend.pop_front();
            if (ev == 2'b11) begin
               m_en = 1'b1; m_lv = 1'b1;
            end else if (ev[1]) begin
               if (m_pc < 7) begin m_pc = m_pc + 1; m_en = 1'b1; end
               else m_rj = 1'b1;
            end else if (ev[0]) begin
               if (m_pc > 0) begin m_pc = m_pc - 1; m_lv = 1'b1; end
               else m_rj = 1'b1;
            end
         end
      end
   end

   // Window observation results.
   int   n_en, n_lv, n_rj, fi_en, fi_any, tot_bad;
   int   en_pc [8];
   logic empty_first;

   task automatic window(input logic b, input logic f, input int hi, input int total);
      n_en = 0; n_lv = 0; n_rj = 0; fi_en = -1; fi_any = -1;
      for (int i = 0; i < total; i++) begin
         bus.back_sensor  = (i < hi) ? b : 1'b0;
         bus.front_sensor = (i < hi) ? f : 1'b0;
         @(negedge clk);
         if (bus.full !== (bus.pcount == 3'd7) || bus.empty !== (bus.pcount == 3'd0))
            tot_bad++;
         if (bus.enter_stb) begin
            if (n_en < 8) en_pc[n_en] = int'(bus.pcount);
            if (fi_en < 0) begin fi_en = i; empty_first = bus.empty; end
            n_en++;
         end
         if (bus.leave_stb) n_lv++;
         if (bus.rej_stb)   n_rj++;
         if ((bus.enter_stb || bus.leave_stb || bus.rej_stb) && fi_any < 0) fi_any = i;
      end
   endtask

   task automatic do_reset(input logic b_hold);
      rst = 1'b1;
      bus.back_sensor  = b_hold;
      bus.front_sensor = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic load(input int n);
      do_reset(1'b0);
      window(1'b0, 1'b0, 0, LO);
      for (int i = 0; i < n; i++) window(1'b1, 1'b0, HI, HI + LO);
   endtask

   typedef struct {
      int   start;
      logic b;
      logic f;
      int   pc;
      int   en;
      int   lv;
      int   rj;
   } vec_t;

   vec_t vecs [10];

   int   bl, fl;
   logic bv, fv;

   initial begin
      vecs[0] = '{0, 1'b1, 1'b0, 1, 1, 0, 0};
      vecs[1] = '{3, 1'b1, 1'b0, 4, 1, 0, 0};
      vecs[2] = '{6, 1'b1, 1'b0, 7, 1, 0, 0};
      vecs[3] = '{7, 1'b1, 1'b0, 7, 0, 0, 1};
      vecs[4] = '{5, 1'b0, 1'b1, 4, 0, 1, 0};
      vecs[5] = '{1, 1'b0, 1'b1, 0, 0, 1, 0};
      vecs[6] = '{0, 1'b0, 1'b1, 0, 0, 0, 1};
      vecs[7] = '{7, 1'b1, 1'b1, 7, 1, 1, 0};
      vecs[8] = '{0, 1'b1, 1'b1, 0, 1, 1, 0};
      vecs[9] = '{4, 1'b1, 1'b1, 4, 1, 1, 0};
      tot_bad = 0;

      // Reset state, observed while rst is still high.
      rst = 1'b1;
      bus.back_sensor  = 1'b0;
      bus.front_sensor = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_pcount", int'(bus.pcount), 0);
      check("rst_empty",  int'(bus.empty), 1);
      check("rst_full",   int'(bus.full), 0);
      check("rst_strobes", int'(bus.enter_stb) + int'(bus.leave_stb) + int'(bus.rej_stb), 0);
      rst = 1'b0;
      window(1'b0, 1'b0, 0, LO);
      check("post_rst_strobes", n_en + n_lv + n_rj, 0);

      // Three isolated entries from empty.
      for (int k = 1; k <= 3; k++) begin
         window(1'b1, 1'b0, HI, HI + LO);
         check($sformatf("entry%0d_pcount", k), int'(bus.pcount), k);
         check($sformatf("entry%0d_enter", k), n_en, 1);
         check($sformatf("entry%0d_pc_at_stb", k), en_pc[0], k);
         check($sformatf("entry%0d_latency", k), fi_en, LAT - 1);
         if (k == 1) check("empty_falls_with_entry", int'(empty_first), 0);
      end

      // Single-event vectors from a preloaded occupancy.
      foreach (vecs[v]) begin
         load(vecs[v].start);
         check($sformatf("v%0d_load", v), int'(bus.pcount), vecs[v].start);
         window(vecs[v].b, vecs[v].f, HI, HI + LO);
         check($sformatf("v%0d_pcount", v), int'(bus.pcount), vecs[v].pc);
         check($sformatf("v%0d_enter", v), n_en, vecs[v].en);
         check($sformatf("v%0d_leave", v), n_lv, vecs[v].lv);
         check($sformatf("v%0d_rej", v), n_rj, vecs[v].rj);
         check($sformatf("v%0d_full", v), int'(bus.full), int'(vecs[v].pc == 7));
         check($sformatf("v%0d_empty", v), int'(bus.empty), int'(vecs[v].pc == 0));
         check($sformatf("v%0d_latency", v), fi_any, LAT - 1);
      end

      // Back beam blocked through reset release: no event until a fresh rise.
      do_reset(1'b1);
      window(1'b1, 1'b0, 10, 10);
      check("held_rst_strobes", n_en + n_lv + n_rj, 0);
      check("held_rst_pcount", int'(bus.pcount), 0);
      window(1'b0, 1'b0, 0, GAP);
      window(1'b1, 1'b0, HI, HI + LO);
      check("held_rst_then_rise_pcount", int'(bus.pcount), 1);
      check("held_rst_then_rise_enter", n_en, 1);

      // Reset lands while an exit is in flight.
      load(4);
      bus.front_sensor = 1'b1;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_pcount", int'(bus.pcount), 0);
      check("mid_rst_leave", int'(bus.leave_stb), 0);
      @(negedge clk);
      rst = 1'b0;
      window(1'b0, 1'b0, 0, LO + 4);
      check("mid_rst_after_pcount", int'(bus.pcount), 0);
      check("mid_rst_after_strobes", n_en + n_lv + n_rj, 0);

`ifdef QC_DEBOUNCE_EN
      load(0);
      if (DEB > 1) begin
         window(1'b1, 1'b0, DEB - 1, DEB - 1 + LO);
         check("glitch_enter", n_en, 0);
         check("glitch_pcount", int'(bus.pcount), 0);
      end
      window(1'b1, 1'b0, DEB + 2, DEB + 2 + LO + 2);
      check("deb_pulse_enter", n_en, 1);
      check("deb_pulse_latency", fi_en, LAT - 1);
      check("deb_pulse_pcount", int'(bus.pcount), 1);
`endif

      // Random traffic, biased per phase to reach both saturation limits.
      do_reset(1'b0);
      window(1'b0, 1'b0, 0, LO);
      bv = 1'b0; fv = 1'b0; bl = MINL; fl = MINL;
      for (int p = 0; p < 3; p++) begin
         for (int c = 0; c < 600; c++) begin
            if (bl == 0) begin
               bv = ~bv;
               if (bv)          bl = int'($urandom_range(MINL, MINL + 4));
               else if (p == 0) bl = int'($urandom_range(MINL, MINL + 2));
               else if (p == 1) bl = int'($urandom_range(MINL + 6, MINL + 14));
               else             bl = int'($urandom_range(MINL, MINL + 8));
            end
            if (fl == 0) begin
               fv = ~fv;
               if (fv)          fl = int'($urandom_range(MINL, MINL + 4));
               else if (p == 0) fl = int'($urandom_range(MINL + 6, MINL + 14));
               else if (p == 1) fl = int'($urandom_range(MINL, MINL + 2));
               else             fl = int'($urandom_range(MINL, MINL + 8));
            end
            bl--; fl--;
            bus.back_sensor  = bv;
            bus.front_sensor = fv;
            @(negedge clk);
            check($sformatf("rand_p%0d_c%0d {pc,full,empty,en,lv,rj}", p, c),
                  int'({bus.pcount, bus.full, bus.empty, bus.enter_stb, bus.leave_stb, bus.rej_stb}),
                  int'({3'(m_pc), m_pc == 7, m_pc == 0, m_en, m_lv, m_rj}));
         end
      end

      check("flags_track_pcount", tot_bad, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/queue_counter.md
QUEUE_COUNTER -- requirements
Module: queue_counter

Interface
REQ-001 Parameter DEB_CYCLES, default 4: consecutive stable cycles the debounce filter requires; range 1-15; used only when QC_DEBOUNCE_EN is defined.
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 back_sensor  input  1  asynchronous photocell at the queue tail; high = beam blocked; a rising edge is one person entering.
REQ-005 front_sensor  input  1  asynchronous photocell at the queue head; high = beam blocked; a rising edge is one person leaving.
REQ-006 pcount  output  3  registered number of people in queue, 0-7; feeds the wait-time lookup.
REQ-007 full  output  1  registered; high exactly when pcount==7.
REQ-008 empty  output  1  registered; high exactly when pcount==0.
REQ-009 enter_stb  output  1  registered one-cycle pulse in the cycle pcount first shows an accepted entry.
REQ-010 leave_stb  output  1  registered one-cycle pulse in the cycle pcount first shows an accepted exit.
REQ-011 rej_stb  output  1  registered one-cycle pulse when an event is discarded: entry at full or exit at empty.

Function
REQ-012 Each sensor passes through its own 2-flop synchronizer, then a rising-edge detector comparing the synchronized level with a history flop.
REQ-013 Without QC_DEBOUNCE_EN, a sensor sampled high at edge k, low at edge k-1, yields an updated pcount/strobe visible after edge k+2 (3-edge latency).
REQ-014 Only rising edges count; falling edges and a held-high level produce no further events.
REQ-015 Back event alone, pcount<7: pcount+1, enter_stb=1.
REQ-016 Front event alone, pcount>0: pcount-1, leave_stb=1.
REQ-017 Back event alone at pcount==7: pcount holds at 7 (no wrap to 0), rej_stb=1, enter_stb=0.
REQ-018 Front event alone at pcount==0: pcount holds at 0 (no wrap to 7), rej_stb=1, leave_stb=0.
REQ-019 Back and front events detected in the same cycle: pcount unchanged at any value including 0 and 7; enter_stb=1, leave_stb=1, rej_stb=0.
REQ-020 full and empty are registered from the next pcount value, so they always agree with pcount in the same cycle.
REQ-021 Strobes are 0 in every cycle without a qualifying event; at most one event per sensor per cycle.
REQ-022 pcount arithmetic is 3-bit unsigned; saturation at 0 and 7 is explicit, never via overflow.

Reset
REQ-023 While rst is high at a rising edge: pcount=0, empty=1, full=0, enter_stb=leave_stb=rej_stb=0.
REQ-024 Synchronizer, history and filter flops reset to 1 (blocked), so a sensor held high across reset release produces no event; its first counted event is the next low-to-high transition.
REQ-025 rst asserted mid-operation discards any event in the pipeline; no strobe appears in the cycle after reset release.
REQ-026 rst has priority over every event in the same cycle.

Configuration
REQ-027 Macro QC_DEBOUNCE_EN: when defined, each synchronized sensor feeds a filter whose output changes only after the synchronized input has differed from it for DEB_CYCLES consecutive cycles; edge detection uses the filter output.
REQ-028 With QC_DEBOUNCE_EN, latency from first stable high sample to pcount update is 3+DEB_CYCLES edges; a glitch shorter than DEB_CYCLES cycles produces no event and resets the filter counter.
REQ-029 Without QC_DEBOUNCE_EN, the filter and DEB_CYCLES logic are absent and REQ-013 latency applies; port list identical in both builds.

Verification
REQ-030 Reset, then 3 isolated back pulses (4 cycles high, 6 low) -> pcount 0->1->2->3, three enter_stb pulses, empty falls with first entry.
REQ-031 From pcount=7, one back pulse -> pcount stays 7, full=1, single rej_stb pulse, enter_stb=0; from pcount=0, one front pulse -> pcount 0, empty=1, single rej_stb.
REQ-032 pcount=7, back and front rise on the same edge -> pcount stays 7, enter_stb and leave_stb both pulse once, rej_stb=0; repeat at pcount=0 -> pcount stays 0.
REQ-033 back_sensor held high through rst and 10 cycles beyond -> pcount remains 0, no strobes; then low 3 cycles, high -> pcount=1.
REQ-034 QC_DEBOUNCE_EN, DEB_CYCLES=4: 2-cycle back glitch -> no event; 6-cycle pulse -> pcount+1 exactly 7 edges after first high sample.
REQ-035 pcount=4, rst asserted 1 cycle after a front edge is sampled -> pcount=0 after reset, no leave_stb after release.
